// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the oversampling UART RX data sampler.
// Helpers work at a fixed maximum width; callers resize to their own width.
package uart_rx_pkg;

    localparam int MAX_NUM_SAMPLES = 7;
    localparam int OS_MAX_W        = 16;

    typedef enum logic [1:0] {
        OS_IDLE    = 2'd0,
        OS_WAIT    = 2'd1,
        OS_COLLECT = 2'd2,
        OS_HOLD    = 2'd3
    } os_state_t;

    // Centre of the bit period: prescale/2 - 1, one bit wider than prescale.
    function automatic logic [OS_MAX_W:0] os_centre(input logic [OS_MAX_W-1:0] prescale);
        return {2'b00, prescale[OS_MAX_W-1:1]} - (OS_MAX_W+1)'(1);
    endfunction

    function automatic logic os_prescale_legal(input logic [OS_MAX_W-1:0] prescale,
                                               input int                  num_samples);
        return !prescale[0] && (int'(prescale) >= 2*num_samples + 2);
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Serial-line synchroniser; STAGES=0 passes the raw line straight through.
// Flops reset to 1 so the line reads idle out of reset.
module rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_os,
    input  logic rst_os,
    input  logic rx_os,
    output logic rx_sync_os
);

    if (STAGES == 0) begin : g_bypass
        assign rx_sync_os = rx_os;
    end else begin : g_flops
        logic [STAGES-1:0] sync_q;

        always_ff @(posedge clk_os) begin
            if (!rst_os) sync_q <= '1;
            else         sync_q <= STAGES'({sync_q, rx_os});
        end

        assign rx_sync_os = sync_q[STAGES-1];
    end

endmodule

// File: rtl/uart_rx_oversampler.sv
// Majority-vote data sampler: NUM_SAMPLES samples centred on each bit,
// one-cycle valid strobe, noise flag on disagreement, prescale legality flag.
module uart_rx_oversampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_W  = 6,
    parameter int NUM_SAMPLES = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_os,
    input  logic                  rst_os,
    input  logic                  RX_IN_os,
    input  logic [PRESCALE_W-1:0] prescale_os,
    input  logic                  data_samp_en_os,
    input  logic [PRESCALE_W-1:0] edge_count_os,
    output logic                  sampled_bit_os,
    output logic                  sample_valid_os,
    output logic                  noise_err_os,
    output logic                  cfg_err_os
);

    localparam int CW = PRESCALE_W + 1;
    localparam int AW = $clog2(NUM_SAMPLES + 1);
    localparam int H  = (NUM_SAMPLES - 1) / 2;

    localparam logic [1:0] ST_IDLE    = OS_IDLE;
    localparam logic [1:0] ST_WAIT    = OS_WAIT;
    localparam logic [1:0] ST_COLLECT = OS_COLLECT;
    localparam logic [1:0] ST_HOLD    = OS_HOLD;

    logic          rx_s;
    logic [1:0]    state;
    logic          armed;
    logic [AW-1:0] ones, ones_n;
    logic          legal;
    logic [CW-1:0] centre, win_lo, win_hi, edge_x;
    logic          at_zero, capture;

    rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_os     (clk_os),
        .rst_os     (rst_os),
        .rx_os      (RX_IN_os),
        .rx_sync_os (rx_s)
    );

    assign legal   = os_prescale_legal(OS_MAX_W'(prescale_os), NUM_SAMPLES);
    assign centre  = CW'(os_centre(OS_MAX_W'(prescale_os)));
    assign win_lo  = centre - CW'(H);
    assign win_hi  = centre + CW'(H);
    assign edge_x  = CW'(edge_count_os);
    assign at_zero = (edge_count_os == '0);

    // A window may only open once armed, so a bit joined mid-way is never voted.
    assign capture = (state == ST_WAIT && armed && edge_x == win_lo) ||
                     (state == ST_COLLECT && !at_zero);
    assign ones_n  = ((state == ST_COLLECT) ? ones : '0) + AW'(rx_s);

    always_ff @(posedge clk_os) begin
        if (!rst_os) begin
            state           <= ST_IDLE;
            armed           <= 1'b0;
            ones            <= '0;
            sampled_bit_os  <= 1'b1;
            sample_valid_os <= 1'b0;
            noise_err_os    <= 1'b0;
            cfg_err_os      <= 1'b0;
        end else begin
            cfg_err_os      <= !legal;
            sample_valid_os <= 1'b0;
            if (!data_samp_en_os || !legal) begin
                state <= ST_IDLE;
                armed <= 1'b0;
                ones  <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_WAIT;
                        armed <= (edge_x < win_lo);
                    end
                    ST_WAIT: if (at_zero) armed <= 1'b1;
                    // edge_count back at 0 mid-collection means the counter resynced
                    ST_COLLECT, ST_HOLD: if (at_zero) begin
                        state <= ST_WAIT;
                        armed <= 1'b1;
                        ones  <= '0;
                    end
                    default: state <= ST_IDLE;
                endcase
                if (capture) begin
                    ones <= ones_n;
                    if (edge_x == win_hi) begin
                        state           <= ST_HOLD;
                        sampled_bit_os  <= (ones_n > AW'(H));
                        sample_valid_os <= 1'b1;
                        noise_err_os    <= (ones_n != '0) && (ones_n != AW'(NUM_SAMPLES));
                    end else begin
                        state <= ST_COLLECT;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Directed bench: three sampler configurations driven from one bit-level stimulus.
// u_c sees the line pre-delayed by two clocks to stand in for its missing synchroniser.
module tb_uart_rx_oversampler;

    localparam int PW = 6;

    logic          clk_os = 1'b0;
    logic          rst_os, rx, en;
    logic          rx_d1 = 1'b1, rx_d2 = 1'b1;
    logic [PW-1:0] prescale, edge_cnt;
    logic          sb_a, vld_a, noise_a, cfg_a;
    logic          sb_b, vld_b, noise_b, cfg_b;
    logic          sb_c, vld_c, noise_c, cfg_c;
    int            tests = 0, fails = 0;
    int            na, nb, nc, se_a, se_b, se_c;

    always #5 clk_os = ~clk_os;

    always @(posedge clk_os) begin
        rx_d1 <= rx;
        rx_d2 <= rx_d1;
    end

    uart_rx_oversampler #(.PRESCALE_W(PW), .NUM_SAMPLES(3), .SYNC_STAGES(2)) u_a (
        .clk_os(clk_os), .rst_os(rst_os), .RX_IN_os(rx), .prescale_os(prescale),
        .data_samp_en_os(en), .edge_count_os(edge_cnt), .sampled_bit_os(sb_a),
        .sample_valid_os(vld_a), .noise_err_os(noise_a), .cfg_err_os(cfg_a));

    uart_rx_oversampler #(.PRESCALE_W(PW), .NUM_SAMPLES(5), .SYNC_STAGES(2)) u_b (
        .clk_os(clk_os), .rst_os(rst_os), .RX_IN_os(rx), .prescale_os(prescale),
        .data_samp_en_os(en), .edge_count_os(edge_cnt), .sampled_bit_os(sb_b),
        .sample_valid_os(vld_b), .noise_err_os(noise_b), .cfg_err_os(cfg_b));

    uart_rx_oversampler #(.PRESCALE_W(PW), .NUM_SAMPLES(3), .SYNC_STAGES(0)) u_c (
        .clk_os(clk_os), .rst_os(rst_os), .RX_IN_os(rx_d2), .prescale_os(prescale),
        .data_samp_en_os(en), .edge_count_os(edge_cnt), .sampled_bit_os(sb_c),
        .sample_valid_os(vld_c), .noise_err_os(noise_c), .cfg_err_os(cfg_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        na = 0; nb = 0; nc = 0;
        se_a = -1; se_b = -1; se_c = -1;
    endtask

    // Drive edge_count first..last-1; rxp/enp give the raw line and enable per edge.
    task automatic run_bit(input int first, input int last,
                           input logic [15:0] rxp, input logic [15:0] enp);
        for (int e = first; e < last; e++) begin
            edge_cnt = PW'(e);
            rx       = rxp[e];
            en       = enp[e];
            @(negedge clk_os);
            if (vld_a) begin na++; se_a = e; end
            if (vld_b) begin nb++; se_b = e; end
            if (vld_c) begin nc++; se_c = e; end
        end
    endtask

    initial begin
        rst_os = 1'b0; en = 1'b0; rx = 1'b1; prescale = PW'(16); edge_cnt = '0;
        clr();
        repeat (3) @(negedge clk_os);
        chk("reset_a", {sb_a, vld_a, noise_a, cfg_a}, 4'b1000);
        chk("reset_b", {sb_b, vld_b, noise_b, cfg_b}, 4'b1000);
        chk("reset_c", {sb_c, vld_c, noise_c, cfg_c}, 4'b1000);
        rst_os = 1'b1;

        // line high for a full bit
        clr(); run_bit(0, 16, 16'hFFFF, 16'hFFFF);
        chk("ones_lat_a", se_a, 8);
        chk("ones_lat_b", se_b, 9);
        chk("ones_lat_c", se_c, 8);
        chk("ones_cnt_a", na, 1);
        chk("ones_val_a", {sb_a, noise_a}, 2'b10);

        clr(); run_bit(0, 16, 16'h0000, 16'hFFFF);
        chk("zero_val_a", {sb_a, noise_a}, 2'b00);
        chk("zero_val_b", {sb_b, noise_b}, 2'b00);
        chk("zero_val_c", {sb_c, noise_c}, 2'b00);

        // synced samples: a/c see 1,1,0 ; b sees 0,1,1,0,0
        clr(); run_bit(0, 16, 16'h0030, 16'hFFFF);
        chk("mix_val_a", {sb_a, noise_a}, 2'b11);
        chk("mix_val_b", {sb_b, noise_b}, 2'b01);
        chk("mix_val_c", {sb_c, noise_c}, 2'b11);
        chk("mix_cnt", na + nb + nc, 3);

        // prescale 8: legal for 3 samples, illegal for 5
        prescale = PW'(8); edge_cnt = PW'(7); rx = 1'b1; en = 1'b1;
        @(negedge clk_os);
        chk("cfg8_b", cfg_b, 1);
        chk("cfg8_a", cfg_a, 0);
        clr();
        repeat (3) run_bit(0, 8, 16'hFFFF, 16'hFFFF);
        chk("cfg8_nostrobe_b", nb, 0);
        chk("cfg8_hold_b", sb_b, 0);
        chk("p8_cnt_a", na, 3);
        chk("p8_cnt_c", nc, 3);
        chk("p8_lat_a", se_a, 4);
        chk("p8_bit_a", sb_a, 1);

        prescale = PW'(15); edge_cnt = '0; rx = 1'b0;
        @(negedge clk_os);
        chk("cfg15_a", cfg_a, 1);
        chk("cfg15_c", cfg_c, 1);
        clr();
        repeat (3) run_bit(0, 15, 16'h0000, 16'hFFFF);
        chk("cfg15_nostrobe", na + nb + nc, 0);
        chk("cfg15_hold_a", sb_a, 1);

        prescale = PW'(16); edge_cnt = PW'(15); rx = 1'b1;
        @(negedge clk_os);
        chk("cfg16_clear", {cfg_a, cfg_b, cfg_c}, 3'b000);

        // enable low on edges 7..9: that bit is dropped, the next is voted
        clr(); run_bit(0, 16, 16'hFFFF, 16'hFC7F);
        chk("endrop_none", na + nb + nc, 0);
        clr(); run_bit(0, 16, 16'h0000, 16'hFFFF);
        chk("enback_lat_a", se_a, 8);
        chk("enback_lat_b", se_b, 9);
        chk("enback_val_a", {sb_a, noise_a}, 2'b00);
        chk("enback_cnt", na + nb + nc, 3);

        // single-clock glitch landing on synced edge 7
        clr(); run_bit(0, 16, 16'h0020, 16'hFFFF);
        chk("glitch_cnt_b", nb, 1);
        chk("glitch_val_b", {sb_b, noise_b}, 2'b01);
        chk("glitch_val_a", {sb_a, noise_a}, 2'b01);
        chk("glitch_val_c", {sb_c, noise_c}, 2'b01);

        // reset pulse while collecting
        clr(); run_bit(0, 7, 16'h0000, 16'hFFFF);
        edge_cnt = PW'(7); rst_os = 1'b0;
        #1;
        chk("rst_pre_edge_a", {sb_a, vld_a, noise_a, cfg_a}, 4'b0010);
        @(negedge clk_os);
        chk("rst_mid_a", {sb_a, vld_a, noise_a, cfg_a}, 4'b1000);
        chk("rst_mid_b", {sb_b, vld_b, noise_b, cfg_b}, 4'b1000);
        rst_os = 1'b1;
        run_bit(8, 16, 16'h0000, 16'hFFFF);
        chk("rst_idle_none", na + nb + nc, 0);
        clr(); run_bit(0, 16, 16'h0000, 16'hFFFF);
        chk("rst_recover_lat_a", se_a, 8);
        chk("rst_recover_val_a", {sb_a, noise_a}, 2'b00);
        chk("rst_recover_lat_c", se_c, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversampler.md
Name: uart_rx_oversampler

Overview:
Parametrised successor of the UART receiver's three-sample data sampler. It takes an odd, configurable number of samples centred on each bit period, majority-votes them and reports the result with a one-cycle valid strobe. It also raises a noise flag when the samples disagree and a configuration-error flag for unusable prescale values. It sits between the RX edge/bit counter and the deserializer, start-check, parity-check and stop-check blocks.

Parameters:
PRESCALE_W, 6, width of prescale and edge_count (supports oversampling up to 2^PRESCALE_W-2).
NUM_SAMPLES, 3, samples per bit; odd, 1..7.
SYNC_STAGES, 2, flops on RX_IN before sampling; 0..3, where 0 means sample raw RX_IN.

Ports:
clk_os  in  1  block clock (oversampling clock).
rst_os  in  1  reset; synchronous, active-low.
RX_IN_os  in  1  serial line.
prescale_os  in  PRESCALE_W  oversampling ratio (clocks per bit).
data_samp_en_os  in  1  sampling enable from RX FSM.
edge_count_os  in  PRESCALE_W  position within bit, counts 0..prescale-1.
sampled_bit_os  out  1  voted bit value.
sample_valid_os  out  1  one-cycle strobe: sampled_bit_os updated this cycle.
noise_err_os  out  1  samples of last vote not unanimous; valid alongside sample_valid_os.
cfg_err_os  out  1  prescale illegal (combinational decode of prescale_os, registered).

Behaviour:
- Clock and reset: one clock, clk_os; reset is synchronous and active-low on rst_os.
- Reset values: sampled_bit_os=1 (line idle), sample_valid_os=0, noise_err_os=0, cfg_err_os=0, FSM=IDLE, accumulator=0, sync flops=1.
- Prescale legality:
  - Legal when prescale is even and prescale >= 2*NUM_SAMPLES+2.
  - cfg_err_os is registered each cycle from this check.
  - While illegal: no samples are taken, sample_valid_os stays 0, and sampled_bit_os holds its value.
- Sample window, computed in PRESCALE_W+1 bits, no wrap:
  - C = prescale/2 - 1; H = (NUM_SAMPLES-1)/2.
  - Samples are taken at edge_count = C-H .. C+H inclusive, from the synchronised RX.
  - The window is defined relative to the synchronised signal; the RX counter compensates for SYNC_STAGES latency.
- FSM states: IDLE, WAIT, COLLECT, HOLD.
  - IDLE: en=0. Goes to WAIT when en=1 and prescale is legal.
  - WAIT: go to COLLECT when edge_count==C-H; that sample is captured in the same cycle.
  - COLLECT: capture one sample per cycle, incrementing the ones-count and sample-count.
    - When the sample at C+H is captured, go to HOLD.
    - On that same edge: sampled_bit_os <= (ones > H), sample_valid_os <= 1 for exactly one cycle, noise_err_os <= (ones != 0 && ones != NUM_SAMPLES), counting the final sample.
    - Latency: outputs are visible the cycle after the edge where edge_count==C+H.
  - HOLD: wait for edge_count==0 (next bit), then clear the accumulator and go to WAIT.
    - If C-H==0, which is impossible under legality, this is not applicable.
- en deasserted in any state: go to IDLE next cycle, clear the accumulator, suppress any pending strobe. sampled_bit_os and noise_err_os hold.
- en reasserted mid-bit after WAIT's window start: stay in WAIT until edge_count==0, then continue as normal. Partial bits are never voted.
- edge_count jumping to 0 while in COLLECT (counter resync): abort the collection, clear, go to WAIT, no strobe.
- Prescale change while en=1: undefined at bit level; the block re-evaluates legality every cycle and returns to IDLE if the value becomes illegal.
- Accumulator width: clog2(NUM_SAMPLES+1) bits; it cannot overflow.
- Reset asserted mid-operation: all state returns to reset values on the next clk_os edge.

Decomposition:
- Package uart_rx_pkg: FSM state enum (os_state_t), MAX_NUM_SAMPLES=7, function os_centre(prescale), function os_prescale_legal(prescale, num_samples).
- Sub-module: rx_sync (SYNC_STAGES-deep synchroniser, reset value 1), instantiated once.

Test Plan:
- Defaults, prescale=16, RX held 1 for a full bit, en=1 -> samples at edge_count 6,7,8; sampled_bit_os=1; sample_valid_os high one cycle after edge 8; noise_err_os=0.
- NUM_SAMPLES=5, prescale=16, RX=0 except a 1-clock glitch at edge 7 -> window 5..9; vote 0; noise_err_os=1; exactly one strobe per bit.
- prescale=8 with NUM_SAMPLES=5 (needs >=12), and prescale=15 (odd) -> cfg_err_os=1 one cycle after application; no sample_valid_os over 3 bit periods; sampled_bit_os unchanged.
- en dropped at edge_count 7 (mid-window), reasserted at edge 10 -> no strobe that bit; the next bit is voted normally with a strobe after edge 8.
- rst_os driven low for one cycle during COLLECT -> next edge: outputs 1/0/0/0, FSM IDLE; reset is not honoured asynchronously, so outputs do not change before the edge.
- SYNC_STAGES=0 vs 2 with identical RX stimulus offset by 2 clocks -> identical sampled_bit_os and strobe sequences.
